// File: rtl/arb_n2x1_gea0_if.sv
// ============================================================================
// Module : arb_n2x1_gea0_if
// Desc   : Two-source / one-sink valid-ready bundle with arbiter status.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface arb_n2x1_gea0_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
);
  logic             i0_valid;
  logic [WIDTH-1:0] i0_data;
  logic             i0_last;
  logic             i0_ready;

  logic             i1_valid;
  logic [WIDTH-1:0] i1_data;
  logic             i1_last;
  logic             i1_ready;

  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             o_last;
  logic             o_ready;

  logic             sel;
  logic             busy;
  logic [CNTW-1:0]  beat_cnt;

  // Arbiter side.
  modport slave (
    input  i0_valid, i0_data, i0_last,
    output i0_ready,
    input  i1_valid, i1_data, i1_last,
    output i1_ready,
    output o_valid, o_data, o_last,
    input  o_ready,
    output sel, busy, beat_cnt
  );

  // Environment side: the two sources and the sink.
  modport master (
    output i0_valid, i0_data, i0_last,
    input  i0_ready,
    output i1_valid, i1_data, i1_last,
    input  i1_ready,
    input  o_valid, o_data, o_last,
    output o_ready,
    input  sel, busy, beat_cnt
  );
endinterface

`default_nettype wire

// File: rtl/arb_n2x1_gea0.sv
// ============================================================================
// Module : arb_n2x1_gea0
// Desc   : Packet-aware 2:1 round-robin arbiter; holds a grant until `last`.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_n2x1_gea0 #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  arb_n2x1_gea0_if.slave    bus
);

  localparam logic [1:0]      c_st_idle = 2'd0;
  localparam logic [1:0]      c_st_gnt0 = 2'd1;
  localparam logic [1:0]      c_st_gnt1 = 2'd2;
  localparam logic [CNTW-1:0] c_cnt_one = CNTW'(1);

  logic [1:0]      r_state;
  logic            r_prio;
  logic            r_sel;
  logic [CNTW-1:0] r_cnt;

  logic [1:0]      w_state_nxt;
  logic            w_prio_nxt;
  logic            w_sel_nxt;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_busy;
  logic            w_xfer;
  logic            w_release;
  logic            w_grant_new;
  logic            w_cnt_max;

  assign w_gnt0 = (r_state == c_st_gnt0);
  assign w_gnt1 = (r_state == c_st_gnt1);
  assign w_busy = w_gnt0 | w_gnt1;

  assign w_xfer    = ((w_gnt0 & bus.i0_valid) | (w_gnt1 & bus.i1_valid)) & bus.o_ready;
  // While a grant is held r_sel always points at the granted requester.
  assign w_release = w_xfer & (r_sel ? bus.i1_last : bus.i0_last);

  assign w_grant_new = (r_state == c_st_idle) & (w_state_nxt != c_st_idle);
  assign w_cnt_max   = &r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_sel_nxt   = r_sel;
    case (r_state)
      c_st_idle: begin
        if (bus.i0_valid && bus.i1_valid) begin
          w_state_nxt = r_prio ? c_st_gnt1 : c_st_gnt0;
          w_sel_nxt   = r_prio;
        end else if (bus.i0_valid) begin
          w_state_nxt = c_st_gnt0;
          w_sel_nxt   = 1'b0;
        end else if (bus.i1_valid) begin
          w_state_nxt = c_st_gnt1;
          w_sel_nxt   = 1'b1;
        end
      end
      c_st_gnt0: begin
        if (w_release) begin
          w_state_nxt = c_st_idle;
          w_prio_nxt  = 1'b1;
        end
      end
      c_st_gnt1: begin
        if (w_release) begin
          w_state_nxt = c_st_idle;
          w_prio_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_prio  <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Beat counter restarts at each grant and keeps its final value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_grant_new) begin
      r_cnt <= '0;
    end else if (w_xfer && !w_cnt_max) begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  assign bus.o_data   = r_sel ? bus.i1_data : bus.i0_data;
  assign bus.o_last   = r_sel ? bus.i1_last : bus.i0_last;
  assign bus.o_valid  = (w_gnt0 & bus.i0_valid) | (w_gnt1 & bus.i1_valid);
  assign bus.i0_ready = w_gnt0 & bus.o_ready;
  assign bus.i1_ready = w_gnt1 & bus.o_ready;

  assign bus.sel      = r_sel;
  assign bus.busy     = w_busy;
  assign bus.beat_cnt = r_cnt;

endmodule

`default_nettype wire
